// File: rtl/sb_3320_route_pkg.sv
// ----------------------------------------------------------------------------
// sb_3320_route_pkg
// Shared constants and types for the route sequencer slice:
//   - node id / route index / route length widths
//   - default sizing of the route buffer and lookup timing
//   - SENTINEL pseudo-node used as "previous" at the start of a route
//   - turn command encodings sent to the motion controller
//   - state enumeration of the sequencer FSM
// ----------------------------------------------------------------------------
package sb_3320_route_pkg;

    localparam int NODE_W         = 5;
    localparam int ADDR_W         = 5;
    localparam int LEN_W          = 6;
    localparam int ROUTE_DEPTH    = 32;
    localparam int LOOKUP_LAT_DEF = 2;
    localparam int INIT_CYC_DEF   = 2;

    localparam logic [NODE_W-1:0] SENTINEL = 5'd27;

    localparam logic [2:0] DIR_STOP    = 3'b000;
    localparam logic [2:0] DIR_FORWARD = 3'b001;
    localparam logic [2:0] DIR_LEFT    = 3'b010;
    localparam logic [2:0] DIR_RIGHT   = 3'b011;
    localparam logic [2:0] DIR_EXTREME = 3'b100;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        QUERY,
        WAIT_LAT,
        ISSUE,
        WAIT_NODE,
        STOP_CMD
    } route_state_t;

endpackage

// File: rtl/sb_3320_route_sequencer_path_buf.sv
// ----------------------------------------------------------------------------
// sb_3320_path_buf
// Route storage: DEPTH entries of NODE_W-bit node ids.
//   clk_50            : write clock
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_addr_a/rd_data_a   : asynchronous read port (neighbour node)
//   rd_addr_b/rd_data_b   : asynchronous read port (current node)
// Contents are deliberately not reset so a route survives a mid-run reset.
// ----------------------------------------------------------------------------
module sb_3320_path_buf
    import sb_3320_route_pkg::*;
#(
    parameter int DEPTH = ROUTE_DEPTH
) (
    input  logic              clk_50,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NODE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [NODE_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [NODE_W-1:0] rd_data_b
);

    logic [NODE_W-1:0] mem [DEPTH];

    // Plain register file write; no reset on purpose.
    always_ff @(posedge clk_50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/sb_3320_route_sequencer.sv
// ----------------------------------------------------------------------------
// sb_3320_route_sequencer
// Walks a stored route, queries the external direction lookup for each
// (previous, current, next) triple and hands the resulting turn command to
// the motion controller, advancing on each node-detect pulse.
//   clk_50, rst_n            : clock, synchronous active-low reset
//   path_wr_en/addr/data     : route buffer write (IDLE only)
//   path_len, start          : route length and start request (IDLE only)
//   abort                    : stop an active traversal
//   node_detect              : bot reached the next node
//   map_start                : lookup enable, high from first cycle after reset
//   map_prev/cur/next        : lookup query
//   map_dir                  : lookup result, valid LOOKUP_LAT cycles after query
//   cmd_valid/ready/dir/node : turn command handshake
//   busy, done, error, step_idx : status
// ----------------------------------------------------------------------------
module sb_3320_route_sequencer
    import sb_3320_route_pkg::*;
#(
    parameter int DEPTH      = ROUTE_DEPTH,
    parameter int LOOKUP_LAT = LOOKUP_LAT_DEF,
    parameter int INIT_CYC   = INIT_CYC_DEF
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              path_wr_en,
    input  logic [ADDR_W-1:0] path_wr_addr,
    input  logic [NODE_W-1:0] path_wr_data,
    input  logic [LEN_W-1:0]  path_len,
    input  logic              start,
    input  logic              abort,
    input  logic              node_detect,
    output logic              map_start,
    output logic [NODE_W-1:0] map_prev,
    output logic [NODE_W-1:0] map_cur,
    output logic [NODE_W-1:0] map_next,
    input  logic [2:0]        map_dir,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_dir,
    output logic [NODE_W-1:0] cmd_node,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] step_idx
);

    localparam int LAT_W  = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
    localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

    route_state_t      state;
    logic [ADDR_W-1:0] step;
    logic [LEN_W-1:0]  len_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [INIT_W-1:0] init_cnt;
    logic              aborted;

    logic              buf_wr_en;
    logic [ADDR_W-1:0] nbr_addr;
    logic [NODE_W-1:0] nbr_node;
    logic [NODE_W-1:0] cur_node;
    logic              abortable;
    logic              last_step;

    assign buf_wr_en = path_wr_en && (state == IDLE);
    assign nbr_addr  = step + ADDR_W'(1);
    assign abortable = (state == QUERY) || (state == WAIT_LAT) ||
                       (state == ISSUE) || (state == WAIT_NODE);
    // True when the step being left is the second-to-last node, i.e. the
    // incremented index lands on the final node of the route.
    assign last_step = (({1'b0, step} + LEN_W'(1)) == (len_q - LEN_W'(1)));
    assign step_idx  = step;

    // Port A serves the neighbour p[i+1]; port B serves p[i].
    sb_3320_path_buf #(
        .DEPTH(DEPTH)
    ) u_path_buf (
        .clk_50    (clk_50),
        .wr_en     (buf_wr_en),
        .wr_addr   (path_wr_addr),
        .wr_data   (path_wr_data),
        .rd_addr_a (nbr_addr),
        .rd_data_a (nbr_node),
        .rd_addr_b (step),
        .rd_data_b (cur_node)
    );

    // Sequencer FSM with all outputs registered. Abort is checked ahead of
    // the per-state logic so it beats node_detect and lookup capture.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state     <= INIT;
            step      <= '0;
            len_q     <= '0;
            lat_cnt   <= '0;
            init_cnt  <= '0;
            aborted   <= 1'b0;
            map_start <= 1'b0;
            map_prev  <= '0;
            map_cur   <= '0;
            map_next  <= '0;
            cmd_valid <= 1'b0;
            cmd_dir   <= DIR_STOP;
            cmd_node  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            map_start <= 1'b1;
            if (abort && abortable) begin
                // A pending turn command is withdrawn for one cycle before
                // the stop command is raised; elsewhere stop is raised at once.
                state     <= STOP_CMD;
                aborted   <= 1'b1;
                cmd_valid <= (state != ISSUE);
                cmd_dir   <= DIR_STOP;
                cmd_node  <= cur_node;
            end else begin
                case (state)
                    INIT: begin
                        if (init_cnt == INIT_W'(INIT_CYC - 1)) begin
                            state <= IDLE;
                        end else begin
                            init_cnt <= init_cnt + INIT_W'(1);
                        end
                    end
                    IDLE: begin
                        if (start) begin
                            if ((path_len < LEN_W'(2)) || (path_len > LEN_W'(DEPTH))) begin
                                error <= 1'b1;
                            end else begin
                                len_q   <= path_len;
                                step    <= '0;
                                done    <= 1'b0;
                                error   <= 1'b0;
                                aborted <= 1'b0;
                                busy    <= 1'b1;
                                state   <= QUERY;
                            end
                        end
                    end
                    QUERY: begin
                        // map_cur still holds p[i-1] from the previous query,
                        // so it becomes the new "previous" node.
                        map_prev <= (step == '0) ? SENTINEL : map_cur;
                        map_cur  <= cur_node;
                        map_next <= nbr_node;
                        lat_cnt  <= '0;
                        state    <= WAIT_LAT;
                    end
                    WAIT_LAT: begin
                        if (lat_cnt == LAT_W'(LOOKUP_LAT - 1)) begin
                            cmd_valid <= 1'b1;
                            cmd_node  <= cur_node;
                            if (map_dir > DIR_EXTREME) begin
                                error   <= 1'b1;
                                cmd_dir <= DIR_STOP;
                                state   <= STOP_CMD;
                            end else begin
                                cmd_dir <= map_dir;
                                state   <= ISSUE;
                            end
                        end else begin
                            lat_cnt <= lat_cnt + LAT_W'(1);
                        end
                    end
                    ISSUE: begin
                        if (cmd_ready) begin
                            cmd_valid <= 1'b0;
                            state     <= WAIT_NODE;
                        end
                    end
                    WAIT_NODE: begin
                        if (node_detect) begin
                            step <= step + ADDR_W'(1);
                            if (last_step) begin
                                cmd_valid <= 1'b1;
                                cmd_dir   <= DIR_STOP;
                                cmd_node  <= nbr_node;
                                state     <= STOP_CMD;
                            end else begin
                                state <= QUERY;
                            end
                        end
                    end
                    STOP_CMD: begin
                        if (!cmd_valid) begin
                            cmd_valid <= 1'b1;
                        end else if (cmd_ready) begin
                            cmd_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= !error && !aborted;
                            state     <= IDLE;
                        end
                    end
                    default: state <= INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sb_3320_route_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sb_3320_route_sequencer
// Drives routes into sb_3320_route_sequencer, emulates the direction lookup
// and the motion controller, and compares each handshaked command and the
// final status against a route-level reference model.
// ----------------------------------------------------------------------------
module tb_sb_3320_route_sequencer;

    localparam int SENTINEL_ID = 27;
    localparam int LAT         = 2;

    typedef struct {
        int dir;
        int node;
        int prev;
        int cur;
        int next;
        bit chk_node;
        bit chk_query;
    } cmd_rec_t;

    logic       clk_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       path_wr_en = 1'b0;
    logic [4:0] path_wr_addr = '0;
    logic [4:0] path_wr_data = '0;
    logic [5:0] path_len = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       node_detect = 1'b0;
    logic       map_start;
    logic [4:0] map_prev;
    logic [4:0] map_cur;
    logic [4:0] map_next;
    logic [2:0] map_dir;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [2:0] cmd_dir;
    logic [4:0] cmd_node;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] step_idx;

    int vec_cnt = 0;
    int err_cnt = 0;
    int route [32];
    logic [2:0] ovr [int];
    cmd_rec_t model_q [$];
    int exp_err;
    int exp_done;
    int exp_step;
    logic [2:0] lat_q = 3'b000;

    sb_3320_route_sequencer dut (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .path_wr_en   (path_wr_en),
        .path_wr_addr (path_wr_addr),
        .path_wr_data (path_wr_data),
        .path_len     (path_len),
        .start        (start),
        .abort        (abort),
        .node_detect  (node_detect),
        .map_start    (map_start),
        .map_prev     (map_prev),
        .map_cur      (map_cur),
        .map_next     (map_next),
        .map_dir      (map_dir),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dir      (cmd_dir),
        .cmd_node     (cmd_node),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .step_idx     (step_idx)
    );

    always #5 clk_50 = ~clk_50;

    // Lookup table: explicit entries first, otherwise a fixed legal turn.
    function automatic logic [2:0] lookupDir(input logic [4:0] p, input logic [4:0] c, input logic [4:0] n);
        int key;
        key = int'({p, c, n});
        if (ovr.exists(key)) return ovr[key];
        return 3'(((int'(p) * 7 + int'(c) * 3 + int'(n)) % 4) + 1);
    endfunction

    // One register stage after the query registers: the answer is only
    // correct LOOKUP_LAT cycles after the query is driven.
    always @(posedge clk_50) lat_q <= lookupDir(map_prev, map_cur, map_next);
    assign map_dir = lat_q;

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Route-level reference: one turn per step from the lookup rule, then a
    // stop at the last node; an illegal code or an abort cuts the route short.
    function automatic void buildExpected(input int len, input int abort_step);
        int prev;
        int d;
        model_q.delete();
        exp_err  = 0;
        exp_done = 1;
        for (int k = 0; k < len - 1; k++) begin
            prev = (k == 0) ? SENTINEL_ID : route[k-1];
            d = int'(lookupDir(5'(prev), 5'(route[k]), 5'(route[k+1])));
            if (d > 4) begin
                model_q.push_back('{0, 0, 0, 0, 0, 1'b0, 1'b0});
                exp_err  = 1;
                exp_done = 0;
                exp_step = k;
                return;
            end
            model_q.push_back('{d, route[k], prev, route[k], route[k+1], 1'b1, 1'b1});
            if (k == abort_step) begin
                model_q.push_back('{0, 0, 0, 0, 0, 1'b0, 1'b0});
                exp_done = 0;
                exp_step = k;
                return;
            end
        end
        model_q.push_back('{0, route[len-1], 0, 0, 0, 1'b1, 1'b0});
        exp_step = len - 1;
    endfunction

    task automatic writeRoute(input int len);
        for (int k = 0; k < len; k++) begin
            path_wr_en   = 1'b1;
            path_wr_addr = 5'(k);
            path_wr_data = 5'(route[k]);
            tick();
        end
        path_wr_en = 1'b0;
    endtask

    // Start a route and play the motion controller until the stop command
    // is accepted, then compare everything against the reference model.
    task automatic applyStimulus(input int len, input int abort_step, input int first_stall, input bit nd_in_issue);
        cmd_rec_t got [$];
        int stall;
        int nd_cnt;
        int ab_cnt;
        int turn_idx;
        int ticks;
        int first_valid;
        int held_dir;
        int held_node;
        bit armed;
        bit stop_seen;
        bit first_cmd;
        buildExpected(len, abort_step);
        path_len = 6'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks = 1;
        first_valid = -1;
        stall = 0;
        nd_cnt = 0;
        ab_cnt = 0;
        turn_idx = 0;
        held_dir = 0;
        held_node = 0;
        armed = 1'b0;
        stop_seen = 1'b0;
        first_cmd = 1'b1;
        while (!stop_seen && ticks < 3000) begin
            cmd_ready   = 1'b0;
            node_detect = 1'b0;
            abort       = 1'b0;
            start       = 1'b0;
            path_wr_en  = 1'b0;
            if (first_valid < 0 && cmd_valid) first_valid = ticks;
            if (nd_cnt > 0) begin
                nd_cnt--;
                if (nd_cnt == 0) node_detect = 1'b1;
            end
            if (ab_cnt > 0) begin
                ab_cnt--;
                if (ab_cnt == 0) begin
                    abort = 1'b1;
                    node_detect = 1'($urandom_range(0, 1));
                end
            end
            if (busy && $urandom_range(0, 15) == 0) begin
                start = 1'b1;
                path_len = 6'($urandom_range(0, 63));
            end
            if (busy && $urandom_range(0, 15) == 0) begin
                path_wr_en   = 1'b1;
                path_wr_addr = 5'($urandom);
                path_wr_data = 5'($urandom);
            end
            if (cmd_valid) begin
                if (!armed) begin
                    armed = 1'b1;
                    stall = (first_cmd && first_stall >= 0) ? first_stall : int'($urandom_range(0, 3));
                    held_dir = int'(cmd_dir);
                    held_node = int'(cmd_node);
                end else begin
                    checkOutput("hold_dir", int'(cmd_dir), held_dir);
                    checkOutput("hold_node", int'(cmd_node), held_node);
                end
                if (stall > 0) begin
                    stall--;
                    if (nd_in_issue && first_cmd && stall == 2) node_detect = 1'b1;
                end else begin
                    cmd_ready = 1'b1;
                    armed = 1'b0;
                    first_cmd = 1'b0;
                    got.push_back('{int'(cmd_dir), int'(cmd_node), int'(map_prev), int'(map_cur), int'(map_next), 1'b0, 1'b0});
                    if (cmd_dir == 3'b000) begin
                        stop_seen = 1'b1;
                    end else begin
                        checkOutput("step_at_cmd", int'(step_idx), turn_idx);
                        if (turn_idx == abort_step) ab_cnt = int'($urandom_range(1, 3));
                        else nd_cnt = int'($urandom_range(1, 4));
                        turn_idx++;
                    end
                end
            end
            tick();
            ticks++;
        end
        cmd_ready = 1'b0;
        node_detect = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        path_wr_en = 1'b0;
        checkOutput("stop_reached", int'(stop_seen), 1);
        checkOutput("ncmd", got.size(), model_q.size());
        for (int k = 0; k < got.size() && k < model_q.size(); k++) begin
            checkOutput("cmd_dir", got[k].dir, model_q[k].dir);
            if (model_q[k].chk_node) checkOutput("cmd_node", got[k].node, model_q[k].node);
            if (model_q[k].chk_query) begin
                checkOutput("q_prev", got[k].prev, model_q[k].prev);
                checkOutput("q_cur", got[k].cur, model_q[k].cur);
                checkOutput("q_next", got[k].next, model_q[k].next);
            end
        end
        checkOutput("latency", first_valid, 2 + LAT);
        checkOutput("busy_end", int'(busy), 0);
        checkOutput("valid_end", int'(cmd_valid), 0);
        checkOutput("done_end", int'(done), exp_done);
        checkOutput("error_end", int'(error), exp_err);
        checkOutput("step_end", int'(step_idx), exp_step);
    endtask

    task automatic badStart(input int len);
        path_len = 6'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("badlen_error", int'(error), 1);
        checkOutput("badlen_busy", int'(busy), 0);
        repeat (3) tick();
        checkOutput("badlen_busy_later", int'(busy), 0);
        checkOutput("badlen_valid", int'(cmd_valid), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        int k;

        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        checkOutput("rst_map_start", int'(map_start), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_error", int'(error), 0);
        checkOutput("rst_valid", int'(cmd_valid), 0);
        checkOutput("rst_cmd_dir", int'(cmd_dir), 0);
        checkOutput("rst_cmd_node", int'(cmd_node), 0);
        checkOutput("rst_step", int'(step_idx), 0);
        checkOutput("rst_map_q", int'({map_prev, map_cur, map_next}), 0);
        rst_n = 1'b1;
        tick();
        checkOutput("map_start_rise", int'(map_start), 1);
        tick();

        // Route 0,1,2,5 with fixed lookup answers
        ovr[int'({5'd27, 5'd0, 5'd1})] = 3'b001;
        ovr[int'({5'd0, 5'd1, 5'd2})]  = 3'b011;
        ovr[int'({5'd1, 5'd2, 5'd5})]  = 3'b001;
        ovr[int'({5'd27, 5'd2, 5'd3})] = 3'b100;
        route[0] = 0; route[1] = 1; route[2] = 2; route[3] = 5;
        writeRoute(4);
        applyStimulus(4, -1, 0, 1'b0);

        // Two-node route with an extreme turn
        route[0] = 2; route[1] = 3;
        writeRoute(2);
        applyStimulus(2, -1, -1, 1'b0);

        // Backpressure on first command, node_detect during ISSUE
        route[0] = 0; route[1] = 1; route[2] = 2;
        writeRoute(3);
        applyStimulus(3, -1, 5, 1'b1);

        badStart(33);

        // Abort in WAIT_NODE of step 1
        route[0] = 0; route[1] = 1; route[2] = 2; route[3] = 5;
        writeRoute(4);
        applyStimulus(4, 1, -1, 1'b0);

        badStart(1);

        // Illegal lookup code on the first query
        route[0] = 9; route[1] = 6; route[2] = 8;
        ovr[int'({5'd27, 5'd9, 5'd6})] = 3'b111;
        writeRoute(3);
        applyStimulus(3, -1, -1, 1'b0);

        // Reset in the middle of a route, then replay from the kept buffer
        ovr.delete();
        for (k = 0; k < 5; k++) route[k] = int'($urandom_range(0, 31));
        writeRoute(5);
        path_len = 6'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        checkOutput("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_valid", int'(cmd_valid), 0);
        checkOutput("mid_rst_map_start", int'(map_start), 0);
        checkOutput("mid_rst_step", int'(step_idx), 0);
        checkOutput("mid_rst_map_q", int'({map_prev, map_cur, map_next}), 0);
        rst_n = 1'b1;
        tick();
        checkOutput("mid_map_start", int'(map_start), 1);
        path_len = 6'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("init_ignores_start", int'(busy), 0);
        applyStimulus(5, -1, -1, 1'b0);

        // Randomized routes, first one at full depth
        for (int r = 0; r < 12; r++) begin
            int ab;
            ovr.delete();
            len = (r == 0) ? 32 : int'($urandom_range(2, 32));
            for (k = 0; k < len; k++) route[k] = int'($urandom_range(0, 31));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 2)) : -1;
            if ($urandom_range(0, 4) == 0) begin
                k = int'($urandom_range(0, len - 2));
                ovr[int'({(k == 0) ? 5'(SENTINEL_ID) : 5'(route[k-1]), 5'(route[k]), 5'(route[k+1])})] = 3'($urandom_range(5, 7));
            end
            writeRoute(len);
            applyStimulus(len, ab, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
